// File: rtl/cpu_program_loader_if.sv
// rtl/cpu_program_loader_if.sv - byte stream in and instruction-memory write port of the program loader
interface cpu_program_loader_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  in_valid;
   logic [7:0]            in_data;
   logic                  in_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [15:0]           imem_wdata;

   // slave is the loader's view; master is the stream source / memory side
   modport slave (
      input  in_valid, in_data,
      output in_ready, imem_we, imem_addr, imem_wdata
   );

   modport master (
      output in_valid, in_data,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/cpu_program_loader.sv
// rtl/cpu_program_loader.sv - boot loader writing a length-prefixed big-endian word image into imem
module cpu_program_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 start,
   cpu_program_loader_if.slave  bus,
   output logic                 cpu_rstn,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LEN_HI  = 3'd1;
   localparam logic [2:0] S_LEN_LO  = 3'd2;
   localparam logic [2:0] S_DATA_HI = 3'd3;
   localparam logic [2:0] S_DATA_LO = 3'd4;
   localparam logic [2:0] S_RUN     = 3'd5;
   localparam logic [2:0] S_ERR     = 3'd6;

   localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

   logic [2:0]          state;
   logic [2:0]          state_nx;
   logic [7:0]          len_hi;
   logic [15:0]         len;
   logic [7:0]          hi_byte;
   logic [ADDR_WIDTH:0] idx;
   logic [ADDR_WIDTH:0] idx_inc;
   logic [15:0]         len_new;
   logic                xfer;
   logic                hdr_bad;
   logic                last_word;
   logic                loading;

   assign loading      = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                         (state == S_DATA_HI) || (state == S_DATA_LO);
   assign bus.in_ready = loading;
   assign busy         = loading;
   assign xfer         = bus.in_valid & loading;

   // index is one bit wider than the address so a full 2^ADDR_WIDTH image terminates without wrap
   assign idx_inc   = idx + 1'b1;
   assign len_new   = {len_hi, bus.in_data};
   assign hdr_bad   = (len_new == 16'd0) || ({1'b0, len_new} > CAPACITY);
   assign last_word = (17'(idx_inc) == {1'b0, len});

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (start) state_nx = S_LEN_HI;
         S_LEN_HI:  if (xfer)  state_nx = S_LEN_LO;
         S_LEN_LO:  if (xfer)  state_nx = hdr_bad ? S_ERR : S_DATA_HI;
         S_DATA_HI: if (xfer)  state_nx = S_DATA_LO;
         S_DATA_LO: if (xfer)  state_nx = last_word ? S_RUN : S_DATA_HI;
         S_RUN:     if (start) state_nx = S_LEN_HI;
         S_ERR:     if (start) state_nx = S_LEN_HI;
         default:              state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state          <= S_IDLE;
         len_hi         <= '0;
         len            <= '0;
         hi_byte        <= '0;
         idx            <= '0;
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= '0;
         bus.imem_wdata <= '0;
         cpu_rstn       <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
      end else begin
         state       <= state_nx;
         bus.imem_we <= 1'b0;
         done        <= (state_nx == S_RUN);
         err         <= (state_nx == S_ERR);
         // released one edge after entering RUN so the final word is in memory before the first fetch
         cpu_rstn    <= (state == S_RUN) && (state_nx == S_RUN);
         if (xfer) begin
            case (state)
               S_LEN_HI:  len_hi <= bus.in_data;
               S_LEN_LO: begin
                  len <= len_new;
                  idx <= '0;
               end
               S_DATA_HI: hi_byte <= bus.in_data;
               S_DATA_LO: begin
                  bus.imem_we    <= 1'b1;
                  bus.imem_addr  <= idx[ADDR_WIDTH-1:0];
                  bus.imem_wdata <= {hi_byte, bus.in_data};
                  idx            <= idx_inc;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_cpu_program_loader.sv
// tb/tb_cpu_program_loader.sv - scoreboard bench for cpu_program_loader
module tb_cpu_program_loader;
   localparam int AW = 8;

   logic CLK = 1'b0;
   logic RESET = 1'b0;
   logic start = 1'b0;
   logic cpu_rstn, busy, done, err;

   cpu_program_loader_if #(.ADDR_WIDTH(AW)) bus ();

   cpu_program_loader #(.ADDR_WIDTH(AW)) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .start    (start),
      .bus      (bus.slave),
      .cpu_rstn (cpu_rstn),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 CLK = ~CLK;

   int          checks = 0;
   int          failures = 0;
   logic [23:0] sb[$];
   logic [15:0] mem[0:255];
   logic [15:0] img[0:255];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   always @(posedge CLK) if (bus.imem_we) mem[bus.imem_addr] <= bus.imem_wdata;

   always @(negedge CLK) begin
      logic [23:0] e;
      if (RESET && bus.imem_we) begin
         if (sb.size() == 0) chk("unexpected_we", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            chk("wr_addr", 32'(bus.imem_addr), 32'(e[23:16]));
            chk("wr_data", 32'(bus.imem_wdata), 32'(e[15:0]));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int  n = 0;
      bit  sent = 0;
      bit  rdy;
      while (!sent && n < 40) begin
         @(negedge CLK);
         if (gaps && $urandom_range(0, 1) == 0) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            chk("ready_in_gap", 32'(bus.in_ready), 32'd1);
            @(posedge CLK);
         end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = b;
            rdy = bus.in_ready;
            @(posedge CLK);
            if (rdy) sent = 1;
         end
         n++;
      end
      if (!sent) chk("byte_timeout", 32'd0, 32'd1);
   endtask

   task automatic pulse_start();
      @(negedge CLK);
      bus.in_valid = 1'b0;
      start = 1'b1;
      @(posedge CLK);
      #1;
      chk("start_ready", 32'(bus.in_ready), 32'd1);
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_rstn", 32'(cpu_rstn), 32'd0);
      chk("start_done", 32'(done), 32'd0);
      chk("start_err", 32'(err), 32'd0);
      @(negedge CLK);
      start = 1'b0;
   endtask

   task automatic load(input int n, input bit do_start, input bit gaps, input int ign_at);
      if (do_start) pulse_start();
      send_byte(8'(n >> 8), gaps);
      send_byte(8'(n), gaps);
      for (int w = 0; w < n; w++) begin
         if (w == ign_at) begin
            @(negedge CLK);
            bus.in_valid = 1'b0;
            start = 1'b1;
            @(posedge CLK);
            #1;
            chk("ign_start_ready", 32'(bus.in_ready), 32'd1);
            chk("ign_start_busy", 32'(busy), 32'd1);
            @(negedge CLK);
            start = 1'b0;
         end
         send_byte(img[w][15:8], gaps);
         send_byte(img[w][7:0], gaps);
         sb.push_back({8'(w), img[w]});
      end
      #1;
      chk("last_done", 32'(done), 32'd1);
      chk("last_rstn_low", 32'(cpu_rstn), 32'd0);
      chk("last_we", 32'(bus.imem_we), 32'd1);
      @(posedge CLK);
      #1;
      chk("run_rstn", 32'(cpu_rstn), 32'd1);
      chk("run_done", 32'(done), 32'd1);
      chk("run_we_low", 32'(bus.imem_we), 32'd0);
      chk("run_sb_empty", 32'(sb.size()), 32'd0);
      for (int w = 0; w < n; w++) chk("mem_word", 32'(mem[w]), 32'(img[w]));
   endtask

   task automatic hdr_err(input logic [15:0] len);
      pulse_start();
      send_byte(len[15:8], 1'b0);
      send_byte(len[7:0], 1'b0);
      #1;
      chk("hdr_err", 32'(err), 32'd1);
      chk("hdr_ready", 32'(bus.in_ready), 32'd0);
      chk("hdr_busy", 32'(busy), 32'd0);
      chk("hdr_rstn", 32'(cpu_rstn), 32'd0);
      chk("hdr_done", 32'(done), 32'd0);
      repeat (3) @(negedge CLK);
      chk("hdr_err_hold", 32'(err), 32'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_we"}, 32'(bus.imem_we), 32'd0);
      chk({tag, "_addr"}, 32'(bus.imem_addr), 32'd0);
      chk({tag, "_wdata"}, 32'(bus.imem_wdata), 32'd0);
      chk({tag, "_rstn"}, 32'(cpu_rstn), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (2) @(posedge CLK);
      #1;
      chk_reset_outputs("reset");
      @(negedge CLK);
      RESET = 1'b1;

      // bytes offered in IDLE must not be taken
      @(negedge CLK);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hAA;
      repeat (3) @(posedge CLK);
      #1;
      chk("idle_ready", 32'(bus.in_ready), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);

      img[0] = 16'h1234; img[1] = 16'hABCD; img[2] = 16'h0007;
      load(3, 1'b1, 1'b0, -1);
      load(3, 1'b1, 1'b1, -1);

      hdr_err(16'h0000);
      hdr_err(16'h0101);

      for (int i = 0; i < 256; i++) img[i] = 16'($urandom);
      load(256, 1'b1, 1'b0, -1);

      // asynchronous reset after the second of four words has been written
      for (int i = 0; i < 4; i++) img[i] = 16'h5A00 + 16'(i * 16'h0111);
      pulse_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h04, 1'b0);
      for (int w = 0; w < 2; w++) begin
         send_byte(img[w][15:8], 1'b0);
         send_byte(img[w][7:0], 1'b0);
         sb.push_back({8'(w), img[w]});
      end
      @(negedge CLK);
      bus.in_valid = 1'b0;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      #1;
      chk_reset_outputs("async_rst");
      chk("rst_sb_empty", 32'(sb.size()), 32'd0);
      chk("rst_mem0", 32'(mem[0]), 32'(img[0]));
      chk("rst_mem1", 32'(mem[1]), 32'(img[1]));
      @(negedge CLK);
      RESET = 1'b1;
      for (int i = 0; i < 4; i++) img[i] = 16'hC300 ^ 16'(i * 16'h1357);
      load(4, 1'b1, 1'b0, 2);

      img[0] = 16'hFFFF;
      load(1, 1'b1, 1'b0, -1);

      chk("final_sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
